// File: rtl/msdap_serial_tx_pkg.sv
// Shared types and constants for the MSDAP serial transmitter.
package msdap_tx_pkg;

    localparam int WORD_W          = 16;
    localparam int CLK_DIV_DEFAULT = 35;

    typedef struct packed {
        logic [WORD_W-1:0] l;
        logic [WORD_W-1:0] r;
    } sample_pair_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } tx_state_t;

endpackage

// File: rtl/msdap_serial_tx_if.sv
// Host handshake plus MSDAP serial lines; slave = transmitter, master = host.
interface msdap_serial_tx_if;

    logic                               in_valid;
    logic                               in_ready;
    logic [msdap_tx_pkg::WORD_W-1:0]    in_data_l;
    logic [msdap_tx_pkg::WORD_W-1:0]    in_data_r;
    logic                               DCLK;
    logic                               Frame;
    logic                               InputL;
    logic                               InputR;
    logic                               busy;
    logic [15:0]                        words_sent;

    modport master (
        output in_valid, in_data_l, in_data_r,
        input  in_ready, DCLK, Frame, InputL, InputR, busy, words_sent
    );

    modport slave (
        input  in_valid, in_data_l, in_data_r,
        output in_ready, DCLK, Frame, InputL, InputR, busy, words_sent
    );

endinterface

// File: rtl/msdap_serial_tx_fifo.sv
// Sample-pair FIFO; DEPTH must be a power of two so the pointers wrap naturally.
module msdap_tx_fifo
    import msdap_tx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         SCLK,
    input  logic         Reset,
    input  logic         i_push,
    input  sample_pair_t i_data,
    input  logic         i_pop,
    output sample_pair_t o_data,
    output logic         o_full,
    output logic         o_empty
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    sample_pair_t  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr];

    always_ff @(posedge SCLK) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge SCLK) begin
        if (Reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/msdap_serial_tx.sv
// MSDAP host-side serial transmitter. MSDAP_TX_ZERO_FILL_EN: send zero pairs instead of idling.
// States: IDLE | lines low, waiting for a pair ; SHIFT | a 16-bit word is on the wire
module msdap_serial_tx
    import msdap_tx_pkg::*;
#(
    parameter int CLK_DIV    = CLK_DIV_DEFAULT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             SCLK,
    input  logic             Reset,
    msdap_serial_tx_if.slave bus
);

    localparam logic [7:0] PH_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] PH_HALF = 8'(CLK_DIV / 2);

    tx_state_t    r_state;
    logic [7:0]   r_phase;
    logic         r_dclk;
    logic         r_frame;
    logic         r_input_l;
    logic         r_input_r;
    logic         r_busy;
    logic [15:0]  r_words_sent;
    logic [3:0]   r_bit_idx;
    logic [15:0]  r_shift_l;
    logic [15:0]  r_shift_r;

    logic         w_load;
    logic [7:0]   w_phase_nxt;
    logic         w_full;
    logic         w_empty;
    logic         w_push;
    logic         w_pop;
    logic         w_word_end;
    logic         w_have_word;
    logic         w_start;
    logic [3:0]   w_bit_dec;
    sample_pair_t w_fifo_din;
    sample_pair_t w_fifo_dout;
    sample_pair_t w_next;

    assign w_load      = (r_phase == PH_LAST);
    assign w_phase_nxt = w_load ? 8'd0 : r_phase + 8'd1;
    assign w_push      = bus.in_valid && bus.in_ready;
    assign w_fifo_din  = {bus.in_data_l, bus.in_data_r};
    assign w_word_end  = (r_state == SHIFT) && (r_bit_idx == 4'd0);
    assign w_bit_dec   = r_bit_idx - 4'd1;

`ifdef MSDAP_TX_ZERO_FILL_EN
    // Once running, an empty FIFO still yields a word: an all-zero pair.
    assign w_have_word = !w_empty || (r_state == SHIFT);
`else
    assign w_have_word = !w_empty;
`endif

    assign w_start = w_load && ((r_state == IDLE) || w_word_end) && w_have_word;
    assign w_pop   = w_start && !w_empty;
    assign w_next  = w_empty ? '0 : w_fifo_dout;

    msdap_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .SCLK    (SCLK),
        .Reset   (Reset),
        .i_push  (w_push),
        .i_data  (w_fifo_din),
        .i_pop   (w_pop),
        .o_data  (w_fifo_dout),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Serial outputs are computed at the load point so they update exactly at phase 0.
    always_ff @(posedge SCLK) begin
        if (Reset) begin
            r_state      <= IDLE;
            r_phase      <= 8'd0;
            r_dclk       <= 1'b1;
            r_frame      <= 1'b0;
            r_input_l    <= 1'b0;
            r_input_r    <= 1'b0;
            r_busy       <= 1'b0;
            r_words_sent <= 16'd0;
            r_bit_idx    <= 4'd0;
            r_shift_l    <= 16'd0;
            r_shift_r    <= 16'd0;
        end else begin
            r_phase <= w_phase_nxt;
            r_dclk  <= (w_phase_nxt < PH_HALF);
            if (w_load) begin
                if (w_word_end) begin
                    r_words_sent <= r_words_sent + 16'd1;
                end
                if (w_start) begin
                    r_state   <= SHIFT;
                    r_shift_l <= w_next.l;
                    r_shift_r <= w_next.r;
                    r_bit_idx <= 4'd15;
                    r_input_l <= w_next.l[15];
                    r_input_r <= w_next.r[15];
                    r_frame   <= 1'b1;
                    r_busy    <= 1'b1;
                end else if ((r_state == SHIFT) && !w_word_end) begin
                    r_bit_idx <= w_bit_dec;
                    r_input_l <= r_shift_l[w_bit_dec];
                    r_input_r <= r_shift_r[w_bit_dec];
                    r_frame   <= 1'b0;
                    r_busy    <= 1'b1;
                end else begin
                    r_state   <= IDLE;
                    r_input_l <= 1'b0;
                    r_input_r <= 1'b0;
                    r_frame   <= 1'b0;
                    r_busy    <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready   = !w_full;
    assign bus.DCLK       = r_dclk;
    assign bus.Frame      = r_frame;
    assign bus.InputL     = r_input_l;
    assign bus.InputR     = r_input_r;
    assign bus.busy       = r_busy;
    assign bus.words_sent = r_words_sent;

endmodule

// File: tb/tb_msdap_serial_tx.sv
// Directed bench for msdap_serial_tx: word vectors from a table plus burst, reset and wrap sequences.
module tb_msdap_serial_tx;
    import msdap_tx_pkg::*;

    localparam int CLK_DIV  = 35;
    localparam int WORD_CYC = 16 * CLK_DIV;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic [15:0] exp_l;
        logic [15:0] exp_r;
    } vec_t;

    logic   SCLK  = 1'b0;
    logic   Reset = 1'b1;
    longint cyc   = 0;
    int     n_checks = 0;
    int     n_err    = 0;

    vec_t        vecs [4];
    logic [15:0] burst_l [5];
    logic [15:0] burst_r [5];

    msdap_serial_tx_if tx_if ();

    msdap_serial_tx #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (4)
    ) dut (
        .SCLK  (SCLK),
        .Reset (Reset),
        .bus   (tx_if)
    );

    always #5 SCLK = ~SCLK;
    always @(posedge SCLK) cyc <= cyc + 1;

    task automatic tick();
        @(posedge SCLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        repeat (2) tick();
        Reset = 1'b0;
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r, output bit ok);
        ok = 1'b0;
        tx_if.in_valid  = 1'b1;
        tx_if.in_data_l = l;
        tx_if.in_data_r = r;
        for (int n = 0; n < 4 * CLK_DIV; n++) begin
            if (tx_if.in_ready === 1'b1) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        tx_if.in_valid = 1'b0;
    endtask

    task automatic wait_frame(output bit found, output longint t0);
        found = 1'b0;
        for (int n = 0; n < 4 * CLK_DIV + 20; n++) begin
            if (tx_if.Frame === 1'b1) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        t0 = cyc;
    endtask

    // Samples each bit at the start and end of its DCLK period.
    task automatic capture_body(output logic [15:0] wl, output logic [15:0] wr,
                                output int frames, output bit stable);
        logic a_l, a_r, a_f;
        wl = '0;
        wr = '0;
        frames = 0;
        stable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a_l = tx_if.InputL;
            a_r = tx_if.InputR;
            a_f = tx_if.Frame;
            wl[15-i] = a_l;
            wr[15-i] = a_r;
            if (a_f === 1'b1) frames++;
            repeat (CLK_DIV - 1) tick();
            if (tx_if.InputL !== a_l || tx_if.InputR !== a_r || tx_if.Frame !== a_f)
                stable = 1'b0;
            tick();
        end
    endtask

    task automatic capture_word(output logic [15:0] wl, output logic [15:0] wr,
                                output int frames, output bit stable,
                                output bit found, output longint t0);
        wait_frame(found, t0);
        capture_body(wl, wr, frames, stable);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_dclk"},   32'(tx_if.DCLK), 32'd1);
        chk({tag, "_frame"},  32'(tx_if.Frame), 32'd0);
        chk({tag, "_inl"},    32'(tx_if.InputL), 32'd0);
        chk({tag, "_inr"},    32'(tx_if.InputR), 32'd0);
        chk({tag, "_busy"},   32'(tx_if.busy), 32'd0);
        chk({tag, "_words"},  32'(tx_if.words_sent), 32'd0);
        chk({tag, "_ready"},  32'(tx_if.in_ready), 32'd1);
    endtask

    initial begin
        logic [15:0] wl, wr;
        int          frames, hi, lo, n;
        bit          stable, found, ok, any;
        longint      t0, t_prev;

        vecs[0] = '{16'hA5C3, 16'h0001, 16'b1010_0101_1100_0011, 16'b0000_0000_0000_0001};
        vecs[1] = '{16'hFFFF, 16'h0000, 16'b1111_1111_1111_1111, 16'b0000_0000_0000_0000};
        vecs[2] = '{16'h8000, 16'h7FFF, 16'b1000_0000_0000_0000, 16'b0111_1111_1111_1111};
        vecs[3] = '{16'h1234, 16'hFEDC, 16'b0001_0010_0011_0100, 16'b1111_1110_1101_1100};
        burst_l = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
        burst_r = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 16'hEEEE};

        tx_if.in_valid  = 1'b0;
        tx_if.in_data_l = '0;
        tx_if.in_data_r = '0;

        // Reset values and idle behaviour
        Reset = 1'b1;
        repeat (3) tick();
        check_reset_values("rst");
        Reset = 1'b0;
        any = 1'b0;
        repeat (3 * CLK_DIV) begin
            any = any | tx_if.Frame | tx_if.InputL | tx_if.InputR;
            tick();
        end
        chk("idle_lines_low", 32'(any), 32'd0);
        chk("idle_words", 32'(tx_if.words_sent), 32'd0);

        n = 0;
        while (tx_if.DCLK !== 1'b0 && n < 100) begin tick(); n++; end
        while (tx_if.DCLK !== 1'b1 && n < 200) begin tick(); n++; end
        hi = 0;
        while (tx_if.DCLK === 1'b1 && hi < 100) begin hi++; tick(); end
        lo = 0;
        while (tx_if.DCLK === 1'b0 && lo < 100) begin lo++; tick(); end
        chk("dclk_high_cycles", 32'(hi), 32'd17);
        chk("dclk_low_cycles", 32'(lo), 32'd18);

        // Single words from the vector table
        for (int v = 0; v < 4; v++) begin
            do_reset();
            push(vecs[v].l, vecs[v].r, ok);
            chk($sformatf("v%0d_push", v), 32'(ok), 32'd1);
            capture_word(wl, wr, frames, stable, found, t0);
            chk($sformatf("v%0d_frame_seen", v), 32'(found), 32'd1);
            chk($sformatf("v%0d_inl", v), 32'(wl), 32'(vecs[v].exp_l));
            chk($sformatf("v%0d_inr", v), 32'(wr), 32'(vecs[v].exp_r));
            chk($sformatf("v%0d_frame_bits", v), 32'(frames), 32'd1);
            chk($sformatf("v%0d_stable", v), 32'(stable), 32'd1);
            chk($sformatf("v%0d_words", v), 32'(tx_if.words_sent), 32'd1);
`ifndef MSDAP_TX_ZERO_FILL_EN
            chk($sformatf("v%0d_busy_after", v), 32'(tx_if.busy), 32'd0);
            chk($sformatf("v%0d_frame_after", v), 32'(tx_if.Frame), 32'd0);
`endif
        end

        // Five back-to-back pairs through a four-deep FIFO
        do_reset();
        fork
            begin
                bit pok;
                for (int k = 0; k < 5; k++) begin
                    push(burst_l[k], burst_r[k], pok);
                    chk($sformatf("burst_push%0d", k), 32'(pok), 32'd1);
                    if (k == 3) chk("burst_ready_full", 32'(tx_if.in_ready), 32'd0);
                end
            end
            begin
                logic [15:0] bl, br;
                int          bf;
                bit          bs, bfound;
                longint      bt0, bprev;
                bprev = 0;
                for (int k = 0; k < 5; k++) begin
                    capture_word(bl, br, bf, bs, bfound, bt0);
                    chk($sformatf("burst%0d_inl", k), 32'(bl), 32'(burst_l[k]));
                    chk($sformatf("burst%0d_inr", k), 32'(br), 32'(burst_r[k]));
                    chk($sformatf("burst%0d_frame_bits", k), 32'(bf), 32'd1);
                    if (k > 0) chk($sformatf("burst%0d_period", k), 32'(bt0 - bprev), 32'(WORD_CYC));
                    bprev = bt0;
                end
            end
        join
        chk("burst_words", 32'(tx_if.words_sent), 32'd5);
`ifndef MSDAP_TX_ZERO_FILL_EN
        chk("burst_busy_after", 32'(tx_if.busy), 32'd0);
`else
        t_prev = cyc - WORD_CYC;
        for (int z = 0; z < 2; z++) begin
            capture_word(wl, wr, frames, stable, found, t0);
            chk($sformatf("zf%0d_inl", z), 32'(wl), 32'd0);
            chk($sformatf("zf%0d_inr", z), 32'(wr), 32'd0);
            chk($sformatf("zf%0d_frame_bits", z), 32'(frames), 32'd1);
            chk($sformatf("zf%0d_period", z), 32'(t0 - t_prev), 32'(WORD_CYC));
            chk($sformatf("zf%0d_busy", z), 32'(tx_if.busy), 32'd1);
            t_prev = t0;
        end
        chk("zf_words", 32'(tx_if.words_sent), 32'd7);
`endif

        // Reset in the middle of a word, with a stale pair still queued
        do_reset();
        push(16'h1357, 16'h2468, ok);
        wait_frame(found, t0);
        chk("midrst_frame_seen", 32'(found), 32'd1);
        push(16'hFFFF, 16'hFFFF, ok);
        repeat (8 * CLK_DIV + 10 - 1) tick();
        Reset = 1'b1;
        tick();
        check_reset_values("midrst");
        Reset = 1'b0;
        push(16'hC001, 16'h8003, ok);
        capture_word(wl, wr, frames, stable, found, t0);
        chk("midrst_new_frame_seen", 32'(found), 32'd1);
        chk("midrst_new_inl", 32'(wl), 32'h0000_C001);
        chk("midrst_new_inr", 32'(wr), 32'h0000_8003);
        chk("midrst_new_frame_bits", 32'(frames), 32'd1);
        chk("midrst_new_words", 32'(tx_if.words_sent), 32'd1);

        // words_sent wraps from 0xFFFF to 0
        do_reset();
        push(16'h0F0F, 16'hF0F0, ok);
        wait_frame(found, t0);
        chk("wrap_frame_seen", 32'(found), 32'd1);
        #2;
        force dut.r_words_sent = 16'hFFFF;
        #1;
        release dut.r_words_sent;
        chk("wrap_preset", 32'(tx_if.words_sent), 32'h0000_FFFF);
        capture_body(wl, wr, frames, stable);
        chk("wrap_inl", 32'(wl), 32'h0000_0F0F);
        chk("wrap_words", 32'(tx_if.words_sent), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
